if_id_hazard: RTL and testbench

IF/ID pipeline register with integrated load-use hazard detection and control-hazard flush for the 5-stage MIPS pipeline. It captures the fetched instruction and PC+4 from IF and presents them to decode. It checks the decoded instruction against the load currently in EX, the stage fed by the ID/EX register, and generates the stall (PC hold, IF/ID hold, ID/EX control bubble). It squashes the fetched instruction on taken branches and jumps.

---
 rtl/if_id_hazard_pkg.sv | 30 +++
 rtl/if_id_hazard_load_use_detect.sv | 26 ++
 rtl/if_id_hazard.sv | 101 ++++++++++
 tb/tb_if_id_hazard.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/if_id_hazard_pkg.sv
// Shared types and constants for the IF/ID register and hazard unit.
// Opcodes, the bubble instruction word and the stall FSM states.
package if_id_hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LW    = 6'h23;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    RUN,
    LU_STALL
  } hzState_e;

  // Instruction classes that read rt as a source register.
  function automatic logic usesRt(input logic [5:0] op);
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (op == OP_RTYPE): r = 1'b1;
      (op == OP_BEQ):   r = 1'b1;
      (op == OP_SW):    r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/if_id_hazard_load_use_detect.sv
// Load-use hazard detect: decoded instruction vs load in EX.
// Purely combinational; $zero never creates a dependency.
module load_use_detect
  import if_id_hazard_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       valid,
  input  logic       exMemRead,
  input  logic [4:0] exRt,
  output logic       hazard
);

  logic rsHit;
  logic rtHit;

  // Compare the load destination against both source fields.
  always_comb begin
    rsHit  = (exRt == rs);
    rtHit  = usesRt(op) && (exRt == rt);
    hazard = valid && exMemRead && (exRt != 5'd0)
             && (rsHit || rtHit);
  end

endmodule

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use stall and branch/jump flush.
// Optional perf counters under `IF_ID_PERF_CNT_EN.
module if_id_hazard
  import if_id_hazard_pkg::*;
#(
  parameter logic [31:0] NOP_INST = if_id_hazard_pkg::NOP_INST,
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       pc_i,
  input  logic              ex_mem_read_i,
  input  logic [4:0]        ex_rt_i,
  input  logic              branch_taken_i,
  input  logic              jump_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       pc_o,
  output logic              valid_o,
  output logic              stall_o,
`ifdef IF_ID_PERF_CNT_EN
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o,
`endif
  output logic              pc_write_o
);

  hzState_e state;
  hzState_e stateNxt;
  logic     hazard;
  logic     flush;

  load_use_detect uDetect (
    .op        (inst_o[31:26]),
    .rs        (inst_o[25:21]),
    .rt        (inst_o[20:16]),
    .valid     (valid_o),
    .exMemRead (ex_mem_read_i),
    .exRt      (ex_rt_i),
    .hazard    (hazard)
  );

  assign flush = branch_taken_i | jump_i;

  always_comb begin
    stateNxt   = RUN;
    stall_o    = 1'b0;
    unique case (state)
      RUN: begin
        if (hazard && !flush) begin
          stall_o  = 1'b1;
          stateNxt = LU_STALL;
        end
      end
      LU_STALL: begin
        stateNxt = RUN;
      end
      default: stateNxt = RUN;
    endcase
    pc_write_o = !stall_o;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= RUN;
    end else if (flush) begin
      state <= RUN;
    end else begin
      state <= stateNxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inst_o  <= NOP_INST;
      pc_o    <= 32'd0;
      valid_o <= 1'b0;
    end else if (flush) begin
      inst_o  <= NOP_INST;
      pc_o    <= pc_i;
      valid_o <= 1'b0;
    end else if (!stall_o) begin
      inst_o  <= inst_i;
      pc_o    <= pc_i;
      valid_o <= 1'b1;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush)   flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_hazard.sv
// Directed bench for if_id_hazard.
// Counter checks build only with `IF_ID_PERF_CNT_EN.
module tb_if_id_hazard;

  localparam int PW = 2;

  logic        clk;
  logic        rstN;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        exMemRead;
  logic [4:0]  exRt;
  logic        brTaken;
  logic        jump;
  logic [31:0] instO;
  logic [31:0] pcO;
  logic        validO;
  logic        stallO;
  logic        pcWriteO;
`ifdef IF_ID_PERF_CNT_EN
  logic [PW-1:0] stallCnt;
  logic [PW-1:0] flushCnt;
`endif

  int nChecks = 0;
  int nErrors = 0;

  localparam logic [31:0] ADD  = 32'h012A_4020;
  localparam logic [31:0] ADDI0 = 32'h2010_0005;
  localparam logic [31:0] ADDI = 32'h216A_0001;
  localparam logic [31:0] SW   = 32'hAD6A_0000;

  if_id_hazard #(.PERF_W(PW)) dut (
    .clk_i          (clk),
    .rst_n_i        (rstN),
    .inst_i         (inst),
    .pc_i           (pc),
    .ex_mem_read_i  (exMemRead),
    .ex_rt_i        (exRt),
    .branch_taken_i (brTaken),
    .jump_i         (jump),
    .inst_o         (instO),
    .pc_o           (pcO),
    .valid_o        (validO),
    .stall_o        (stallO),
`ifdef IF_ID_PERF_CNT_EN
    .stall_cnt_o    (stallCnt),
    .flush_cnt_o    (flushCnt),
`endif
    .pc_write_o     (pcWriteO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    inst = ADD;
    pc = 32'd4;
    exMemRead = 1'b0;
    exRt = 5'd0;
    brTaken = 1'b0;
    jump = 1'b0;
    repeat (3) tick();
    chk("rst_inst", instO, 32'h0);
    chk("rst_pc", pcO, 32'h0);
    chk("rst_valid", validO, 0);
    chk("rst_stall", stallO, 0);
    chk("rst_pcw", pcWriteO, 1);
`ifdef IF_ID_PERF_CNT_EN
    chk("rst_scnt", stallCnt, 0);
`endif
    @(negedge clk);
    rstN = 1'b1;
    tick();
    chk("first_inst", instO, ADD);
    chk("first_pc", pcO, 32'd4);
    chk("first_valid", validO, 1);

    inst = ADDI0;
    pc = 32'd8;
    exMemRead = 1'b1;
    exRt = 5'd9;
    #1;
    chk("lu_stall", stallO, 1);
    chk("lu_pcw", pcWriteO, 0);
    tick();
    chk("lu_hold_inst", instO, ADD);
    chk("lu_hold_pc", pcO, 32'd4);
    chk("lu_one_cycle", stallO, 0);
    chk("lu_pcw_back", pcWriteO, 1);
    tick();
    chk("lu_adv_inst", instO, ADDI0);
    chk("lu_adv_pc", pcO, 32'd8);

    exRt = 5'd0;
    #1;
    chk("zero_reg", stallO, 0);

    exMemRead = 1'b0;
    inst = ADDI;
    pc = 32'd12;
    tick();
    exMemRead = 1'b1;
    exRt = 5'd10;
    #1;
    chk("addi_rt", stallO, 0);

    exMemRead = 1'b0;
    inst = SW;
    pc = 32'd16;
    tick();
    exMemRead = 1'b1;
    #1;
    chk("sw_rt", stallO, 1);
    brTaken = 1'b1;
    pc = 32'd20;
    #1;
    chk("fl_stall", stallO, 0);
    chk("fl_pcw", pcWriteO, 1);
    tick();
    chk("fl_inst", instO, 32'h0);
    chk("fl_valid", validO, 0);
    chk("fl_pc", pcO, 32'd20);
    brTaken = 1'b0;
    exMemRead = 1'b0;
    inst = ADD;
    pc = 32'd24;
    #1;
    chk("bubble_nostall", stallO, 0);
    tick();
    chk("fl_recover", validO, 1);

    exMemRead = 1'b1;
    exRt = 5'd9;
    tick();
    chk("s2_held", stallO, 0);
    tick();
    chk("s3_on", stallO, 1);
    tick();
    jump = 1'b1;
    tick();
    jump = 1'b0;
    exMemRead = 1'b0;
    chk("jmp_valid", validO, 0);
`ifdef IF_ID_PERF_CNT_EN
    chk("scnt3", stallCnt, 3);
    chk("fcnt2", flushCnt, 2);
    tick();
    exMemRead = 1'b1;
    tick();
    chk("scnt_wrap", stallCnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
